uart_line_rx: RTL and testbench
===============================

Name: uart_line_rx

Overview:
Synthesizable UART receiver with line assembly, for on-chip observation of the SoC UART TX stream.
- Frame format is parametrised (data bits, parity mode, stop bits).
- Received characters are buffered into lines, closed on a configurable end-of-line character or when the buffer fills.
- Each completed line is drained over a valid/ready byte stream with a last flag.
- Parity and framing errors, and characters dropped while draining, are flagged.

Parameters:
- ClkFreqHz, 40_000_000: system clock frequency in Hz.
- BaudRate, 115200: nominal baud rate. Divisor = ClkFreqHz/(BaudRate*16), integer truncation; divisor must be ≥1.
- DataBits, 8: data bits per frame, legal range 5..8.
- ParityMode, PARITY_NONE: PARITY_NONE, PARITY_EVEN or PARITY_ODD (type parity_e).
- StopBits, 1: stop bits per frame, 1 or 2.
- LineDepth, 81: line buffer capacity in bytes, ≥2.
- EolChar, 8'h0A: end-of-line character.

Ports:
- clk_i, in, 1: system clock.
- rst_ni, in, 1: synchronous active-low reset.
- rx_i, in, 1: serial input, asynchronous, idle high.
- out_valid_o, out, 1: output byte valid.
- out_ready_i, in, 1: consumer ready.
- out_data_o, out, 8: output byte. Zero-extended when DataBits<8.
- out_last_o, out, 1: marks the final byte of the current line.
- line_len_o, out, $clog2(LineDepth+1): length of the line being drained; 0 outside DRAIN.
- parity_err_o, out, 1: one-cycle pulse on a parity mismatch.
- frame_err_o, out, 1: one-cycle pulse on a low stop bit.
- drop_o, out, 1: one-cycle pulse when a good byte is discarded.
- drop_cnt_o, out, 16: saturating count of dropped bytes.

Behaviour:
- Reset: one clock with rst_ni=0, synchronous. All outputs become 0. Both FSMs go to IDLE/FILL. Buffer pointers and drop_cnt are cleared. Reset mid-frame or mid-drain discards all content.
- Input sync: rx_i passes through a 2-flop synchronizer (2-cycle latency) before any use.
- Oversampling: a tick counter runs 0..Divisor-1 and produces one sample tick per wrap. It restarts on every start-bit detection. 16 ticks make one bit.
- RX FSM:
  - IDLE: a falling edge of synced rx goes to START.
  - START: at tick 8, rx=0 goes to DATA; rx=1 is a glitch and returns to IDLE.
  - DATA: samples rx every 16 ticks from mid-bit, LSB first, for DataBits bits.
  - PARITY (only if ParityMode≠NONE): EVEN expects ^data==bit; ODD expects ^data!=bit.
  - STOP: samples StopBits stop bits.
  - Any stop bit 0: frame_err_o pulses, the byte is discarded, and the FSM waits for synced rx=1 before returning to IDLE.
  - Parity mismatch: parity_err_o pulses and the byte is discarded. It does not also raise frame_err for the same frame.
  - Good byte: a one-cycle internal byte strobe is raised at the mid-point of the last stop bit, then the FSM returns to IDLE.
- Line FSM:
  - FILL: each good byte is written at wr_ptr, and wr_ptr increments.
    - If the byte equals EolChar, or wr_ptr reaches LineDepth after the write, the line is closed: go to DRAIN with line_len=wr_ptr. The EOL byte is stored, so line length is ≥1.
  - DRAIN: out_valid_o=1 and out_data_o=buf[rd_ptr]. out_last_o=1 when rd_ptr==line_len-1.
    - Transfer happens when valid&ready; rd_ptr increments.
    - On the transfer with last set, go to FILL the next cycle with both pointers cleared. out_valid_o=0 on that cycle.
    - Good bytes arriving during DRAIN are discarded: drop_o pulses and drop_cnt_o increments, saturating at 16'hFFFF.
  - out_data_o is held stable while valid && !ready.
- Simultaneous events:
  - Byte strobe in the same cycle as the final drain handshake: the byte is dropped, because the state is still DRAIN.
  - Error pulses are independent of the line FSM.
- Output latency: DRAIN is entered one cycle after the closing byte strobe, and the first valid byte appears on that cycle.

Decomposition:
- Package uart_line_pkg holds parity_e, rx_state_e {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}, line_state_e {FILL, DRAIN}, and the divisor helper function.
- Sub-module uart_line_rx_core contains the synchronizer, tick generator and RX FSM. It outputs byte/strobe/error pulses.
- The top level holds the buffer, the line FSM and the drop counter.

Test Plan (ClkFreqHz=40MHz, Baud=115200: Divisor=21, bit=336 cycles):
1. Send "Hi\n" with default parameters, ready=1 → 3 transfers 0x48, 0x69, 0x0A. Last is set on 0x0A. line_len_o=3. No error pulses.
2. Send 81 bytes of 0x41 with no EOL → one line of 81 bytes with last on the 81st. An 82nd byte of 0x42 sent after drain starts a new line.
3. ParityMode=EVEN: send 0x07 with parity bit 0 → parity_err_o pulses once and nothing is buffered. Resend with parity 1 → byte accepted.
4. Force the stop bit to 0 on 0x55 → frame_err_o pulses and the byte is discarded. Receiver recovers once rx goes high, and the next 0x0A yields a 1-byte line.
5. Hold out_ready_i=0 after "A\n", then send 3 more bytes → drop_o pulses 3 times and drop_cnt_o=3. out_data_o stays at 0x41.
6. DataBits=7, StopBits=2: send 0x7F → out_data_o=0x7F. Assert rst_ni=0 mid-frame → all outputs 0 the next cycle, and a subsequent full frame is received correctly.

Source files
------------

// File: rtl/uart_line_pkg.sv
// Shared types and helpers for the UART line receiver.
// Frame/line FSM encodings and the baud divisor calculation.
package uart_line_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    typedef enum logic {
        FILL,
        DRAIN
    } line_state_e;

    // Clock cycles per 1/16 bit, never below one.
    function automatic int baud_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * 16);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_line_rx_core.sv
// Serial front end: input synchronizer, 16x oversampling tick and
// frame FSM producing a byte strobe plus parity/framing error pulses.
module uart_line_rx_core
    import uart_line_pkg::*;
#(
    parameter int      ClkFreqHz  = 40_000_000,
    parameter int      BaudRate   = 115200,
    parameter int      DataBits   = 8,
    parameter parity_e ParityMode = PARITY_NONE,
    parameter int      StopBits   = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       strobe_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);

    localparam int Div = baud_div(ClkFreqHz, BaudRate);
    localparam int TW  = (Div > 1) ? $clog2(Div) : 1;

    rx_state_e       state, state_n;
    logic [2:0]      sync;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic [3:0]      scnt, scnt_n;
    logic [2:0]      bidx, bidx_n;
    logic            sidx, sidx_n;
    logic [7:0]      data, data_n;
    logic            rx_s, fall, tick, mid, par_ok;

    // sync[1:0] is the synchronizer, sync[2] the previous synced level.
    assign rx_s = sync[1];
    assign fall = sync[2] & ~sync[1];
    assign tick = (tcnt == TW'(Div - 1));
    assign mid  = tick && (scnt == 4'd15);

    assign par_ok = (ParityMode == PARITY_ODD) ? ((^data) != rx_s)
                                               : ((^data) == rx_s);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync  <= 3'b111;
            state <= IDLE;
            tcnt  <= '0;
            scnt  <= '0;
            bidx  <= '0;
            sidx  <= 1'b0;
            data  <= '0;
        end else begin
            sync  <= {sync[1:0], rx_i};
            state <= state_n;
            tcnt  <= tcnt_n;
            scnt  <= scnt_n;
            bidx  <= bidx_n;
            sidx  <= sidx_n;
            data  <= data_n;
        end
    end

    always_comb begin
        state_n      = state;
        tcnt_n       = tick ? '0 : tcnt + 1'b1;
        scnt_n       = tick ? scnt + 1'b1 : scnt;
        bidx_n       = bidx;
        sidx_n       = sidx;
        data_n       = data;
        strobe_o     = 1'b0;
        parity_err_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    tcnt_n  = '0;
                    scnt_n  = '0;
                end
            end
            START: begin
                if (tick && scnt == 4'd7) begin
                    scnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        bidx_n  = '0;
                        data_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (mid) begin
                    data_n[bidx] = rx_s;
                    if (bidx == 3'(DataBits - 1)) begin
                        sidx_n  = 1'b0;
                        state_n = (ParityMode == PARITY_NONE) ? STOP : PARITY;
                    end else begin
                        bidx_n = bidx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (mid) begin
                    if (par_ok) begin
                        state_n = STOP;
                    end else begin
                        parity_err_o = 1'b1;
                        state_n      = WAIT_IDLE;
                    end
                end
            end
            STOP: begin
                if (mid) begin
                    if (!rx_s) begin
                        frame_err_o = 1'b1;
                        state_n     = WAIT_IDLE;
                    end else if (sidx == 1'(StopBits - 1)) begin
                        strobe_o = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        sidx_n = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign byte_o = data;

endmodule

// File: rtl/uart_line_rx.sv
// UART receiver with line assembly: good bytes fill a line buffer that
// is drained over valid/ready once an EOL arrives or the buffer fills.
module uart_line_rx
    import uart_line_pkg::*;
#(
    parameter int         ClkFreqHz  = 40_000_000,
    parameter int         BaudRate   = 115200,
    parameter int         DataBits   = 8,
    parameter parity_e    ParityMode = PARITY_NONE,
    parameter int         StopBits   = 1,
    parameter int         LineDepth  = 81,
    parameter logic [7:0] EolChar    = 8'h0A
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           rx_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [7:0]                     out_data_o,
    output logic                           out_last_o,
    output logic [$clog2(LineDepth+1)-1:0] line_len_o,
    output logic                           parity_err_o,
    output logic                           frame_err_o,
    output logic                           drop_o,
    output logic [15:0]                    drop_cnt_o
);

    localparam int LW = $clog2(LineDepth + 1);

    line_state_e   state, state_n;
    logic [7:0]    mem [LineDepth];
    logic [LW-1:0] wr, wr_n, rd, rd_n, len, len_n;
    logic [15:0]   cnt, cnt_n;
    logic [7:0]    rx_byte;
    logic          rx_strobe, wen, last, drop;

    uart_line_rx_core #(
        .ClkFreqHz (ClkFreqHz),
        .BaudRate  (BaudRate),
        .DataBits  (DataBits),
        .ParityMode(ParityMode),
        .StopBits  (StopBits)
    ) u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .byte_o      (rx_byte),
        .strobe_o    (rx_strobe),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= FILL;
            wr    <= '0;
            rd    <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            wr    <= wr_n;
            rd    <= rd_n;
            len   <= len_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wen) mem[wr] <= rx_byte;
    end

    always_comb begin
        state_n = state;
        wr_n    = wr;
        rd_n    = rd;
        len_n   = len;
        cnt_n   = cnt;
        wen     = 1'b0;
        drop    = 1'b0;
        last    = 1'b0;
        unique case (state)
            FILL: begin
                if (rx_strobe) begin
                    wen  = 1'b1;
                    wr_n = wr + 1'b1;
                    if (rx_byte == EolChar || wr_n == LW'(LineDepth)) begin
                        state_n = DRAIN;
                        len_n   = wr_n;
                    end
                end
            end
            DRAIN: begin
                last = (rd == len - 1'b1);
                // The buffer is busy until the consumer takes the last byte.
                if (rx_strobe) begin
                    drop = 1'b1;
                    if (cnt != 16'hFFFF) cnt_n = cnt + 1'b1;
                end
                if (out_ready_i) begin
                    rd_n = rd + 1'b1;
                    if (last) begin
                        state_n = FILL;
                        wr_n    = '0;
                        rd_n    = '0;
                        len_n   = '0;
                    end
                end
            end
            default: state_n = FILL;
        endcase
    end

    assign out_valid_o = (state == DRAIN);
    assign out_last_o  = last;
    assign out_data_o  = out_valid_o ? mem[rd] : '0;
    assign line_len_o  = out_valid_o ? len : '0;
    assign drop_o      = drop;
    assign drop_cnt_o  = cnt;

endmodule

// File: tb/tb_uart_line_rx.sv
// Bench for uart_line_rx: three parameterisations driven by a serial
// frame generator and checked against a line-level reference model.
module tb_uart_line_rx;
    import uart_line_pkg::*;

    localparam int CLK_HZ = 40_000_000;
    localparam int BAUD   = 1_250_000;
    localparam int BIT    = 16 * (CLK_HZ / (BAUD * 16));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
    logic set_a = 1'b1, set_c = 1'b1;
    bit   rnd_ready = 1'b0;

    logic        v_a, l_a, pe_a, fe_a, dr_a;
    logic        v_b, l_b, pe_b, fe_b, dr_b;
    logic        v_c, l_c, pe_c, fe_c, dr_c;
    logic [7:0]  d_a, d_b, d_c;
    logic [6:0]  n_a, n_b, n_c;
    logic [15:0] dc_a, dc_b, dc_c;

    int n_vec = 0, n_bad = 0;
    int cnt_pe[3], cnt_fe[3], cnt_dr[3];
    logic [15:0] exp_q[$];
    logic [15:0] cap_b[$], cap_c[$];
    logic [7:0]  m_line[$];
    bit m_busy = 1'b0, m_hold = 1'b0;
    int m_drops = 0;

    uart_line_rx #(.ClkFreqHz(CLK_HZ), .BaudRate(BAUD)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a),
        .out_valid_o(v_a), .out_ready_i(rdy_a), .out_data_o(d_a),
        .out_last_o(l_a), .line_len_o(n_a), .parity_err_o(pe_a),
        .frame_err_o(fe_a), .drop_o(dr_a), .drop_cnt_o(dc_a));

    uart_line_rx #(.ClkFreqHz(CLK_HZ), .BaudRate(BAUD),
                   .ParityMode(PARITY_EVEN)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b),
        .out_valid_o(v_b), .out_ready_i(rdy_b), .out_data_o(d_b),
        .out_last_o(l_b), .line_len_o(n_b), .parity_err_o(pe_b),
        .frame_err_o(fe_b), .drop_o(dr_b), .drop_cnt_o(dc_b));

    uart_line_rx #(.ClkFreqHz(CLK_HZ), .BaudRate(BAUD),
                   .DataBits(7), .StopBits(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_c),
        .out_valid_o(v_c), .out_ready_i(rdy_c), .out_data_o(d_c),
        .out_last_o(l_c), .line_len_o(n_c), .parity_err_o(pe_c),
        .frame_err_o(fe_c), .drop_o(dr_c), .drop_cnt_o(dc_c));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ent(int len, bit last, logic [7:0] d);
        return {7'(len), last, d};
    endfunction

    // Line-level model: bytes accumulate until EOL or 81 bytes.
    task automatic model_a(input logic [7:0] b);
        int sz;
        if (m_busy) begin
            m_drops++;
        end else begin
            m_line.push_back(b);
            if (b == 8'h0A || m_line.size() == 81) begin
                sz = m_line.size();
                for (int i = 0; i < sz; i++)
                    exp_q.push_back(ent(sz, i == sz - 1, m_line[i]));
                m_line.delete();
                m_busy = m_hold;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (pe_a) cnt_pe[0]++;
        if (fe_a) cnt_fe[0]++;
        if (dr_a) cnt_dr[0]++;
        if (pe_b) cnt_pe[1]++;
        if (fe_b) cnt_fe[1]++;
        if (dr_b) cnt_dr[1]++;
        if (pe_c) cnt_pe[2]++;
        if (fe_c) cnt_fe[2]++;
        if (dr_c) cnt_dr[2]++;
        if (v_a && rdy_a) begin
            e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEADBEEF;
            check("a_xfer", 32'({n_a, l_a, d_a}), e);
        end
        if (v_b && rdy_b) cap_b.push_back({n_b, l_b, d_b});
        if (v_c && rdy_c) cap_c.push_back({n_c, l_c, d_c});
    end

    initial forever begin
        @(posedge clk);
        #1;
        rdy_a = rnd_ready ? 1'($urandom_range(0, 1)) : set_a;
        rdy_c = set_c;
    end

    task automatic drive(input int d, input logic v);
        case (d)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // par: 0 none, 1 correct even parity, 2 inverted parity bit
    task automatic send(input int d, input logic [7:0] b, input int nb,
                        input int par, input bit bad_stop, input int ns,
                        input int gap);
        logic p;
        @(negedge clk);
        drive(d, 1'b0);
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            drive(d, b[i]);
            repeat (BIT) @(negedge clk);
        end
        if (par != 0) begin
            p = ^b;
            if (par == 2) p = ~p;
            drive(d, p);
            repeat (BIT) @(negedge clk);
        end
        for (int i = 0; i < ns; i++) begin
            drive(d, !bad_stop);
            repeat (BIT) @(negedge clk);
        end
        drive(d, 1'b1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] b, input int gap);
        model_a(b);
        send(0, b, 8, 0, 1'b0, 1, gap);
    endtask

    task automatic wait_drain_a();
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("a_drain_left", exp_q.size(), 0);
        @(negedge clk);
        check("a_valid_after_last", v_a, 0);
    endtask

    task automatic wait_cap(input int d, input int n);
        int t = 0;
        while (((d == 1) ? cap_b.size() : cap_c.size()) < n && t < 40 * BIT) begin
            @(negedge clk);
            t++;
        end
        check((d == 1) ? "b_count" : "c_count",
              (d == 1) ? cap_b.size() : cap_c.size(), n);
    endtask

    function automatic logic [31:0] pop_cap(input int d);
        if (d == 1)
            return (cap_b.size() != 0) ? 32'(cap_b.pop_front()) : 32'hDEADBEEF;
        return (cap_c.size() != 0) ? 32'(cap_c.pop_front()) : 32'hDEADBEEF;
    endfunction

    initial begin
        logic [7:0] b;
        int t;

        repeat (2) @(negedge clk);
        check("rst_a", {v_a, d_a, l_a, n_a, pe_a, fe_a, dr_a}, 0);
        check("rst_dc_a", dc_a, 0);
        check("rst_b", {v_b, d_b, l_b, n_b, pe_b, fe_b, dr_b}, 0);
        check("rst_c", {v_c, d_c, l_c, n_c, pe_c, fe_c, dr_c}, 0);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);

        // "Hi\n"
        send_a(8'h48, 0);
        send_a(8'h69, 0);
        send_a(8'h0A, 0);
        wait_drain_a();
        check("a_errs_hi", cnt_pe[0] + cnt_fe[0] + cnt_dr[0], 0);

        // full buffer without EOL, then a fresh line
        for (int i = 0; i < 81; i++) send_a(8'h41, 0);
        send_a(8'h42, 0);
        send_a(8'h0A, 0);
        wait_drain_a();

        // framing error then recovery
        send(0, 8'h55, 8, 0, 1'b1, 1, 2 * BIT);
        check("a_ferr", cnt_fe[0], 1);
        check("a_ferr_nobuf", v_a, 0);
        send_a(8'h0A, 0);
        wait_drain_a();
        check("a_perr_none", cnt_pe[0], 0);

        // stalled consumer: bytes arriving during DRAIN are dropped
        set_a  = 1'b0;
        m_hold = 1'b1;
        send_a(8'h41, 0);
        send_a(8'h0A, 0);
        for (int i = 0; i < 3; i++) send_a(8'h31 + 8'(i), 0);
        repeat (4) @(negedge clk);
        check("a_drop_pulses", cnt_dr[0], m_drops);
        check("a_drop_cnt", dc_a, m_drops);
        check("a_hold_valid", v_a, 1);
        check("a_hold_data", d_a, 8'h41);
        m_hold = 1'b0;
        m_busy = 1'b0;
        set_a  = 1'b1;
        wait_drain_a();

        // random traffic with a random consumer
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) b = 8'h0A;
            send_a(b, $urandom_range(0, 40));
        end
        rnd_ready = 1'b0;
        send_a(8'h0A, 0);
        wait_drain_a();
        check("a_drop_cnt_end", dc_a, m_drops);
        check("a_ferr_end", cnt_fe[0], 1);

        // even parity: wrong parity discarded, correct accepted
        send(1, 8'h07, 8, 2, 1'b0, 1, BIT);
        check("b_perr", cnt_pe[1], 1);
        check("b_ferr_none", cnt_fe[1], 0);
        check("b_nobuf", v_b, 0);
        send(1, 8'h07, 8, 1, 1'b0, 1, 0);
        send(1, 8'h0A, 8, 1, 1'b0, 1, 0);
        wait_cap(1, 2);
        check("b_byte0", pop_cap(1), 32'(ent(2, 1'b0, 8'h07)));
        check("b_byte1", pop_cap(1), 32'(ent(2, 1'b1, 8'h0A)));
        check("b_perr_end", cnt_pe[1], 1);

        // 7 data bits, 2 stop bits
        send(2, 8'h7F, 7, 0, 1'b0, 2, 0);
        send(2, 8'h0A, 7, 0, 1'b0, 2, 0);
        wait_cap(2, 2);
        check("c_byte0", pop_cap(2), 32'(ent(2, 1'b0, 8'h7F)));
        check("c_byte1", pop_cap(2), 32'(ent(2, 1'b1, 8'h0A)));

        // reset mid-drain and mid-frame discards everything
        set_c = 1'b0;
        send(2, 8'h0A, 7, 0, 1'b0, 2, 0);
        t = 0;
        while (!v_c && t < 20 * BIT) begin
            @(negedge clk);
            t++;
        end
        check("c_held", {v_c, l_c, n_c}, {1'b1, 1'b1, 7'd1});
        drive(2, 1'b0);
        repeat (BIT + BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        drive(2, 1'b1);
        @(negedge clk);
        check("rst_mid_c", {v_c, d_c, l_c, n_c, pe_c, fe_c, dr_c}, 0);
        check("rst_mid_dc_a", dc_a, 0);
        rst_n   = 1'b1;
        m_drops = 0;
        set_c   = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("c_flushed", cap_c.size(), 0);
        send(2, 8'h7F, 7, 0, 1'b0, 2, 0);
        send(2, 8'h0A, 7, 0, 1'b0, 2, 0);
        wait_cap(2, 2);
        check("c_post_rst0", pop_cap(2), 32'(ent(2, 1'b0, 8'h7F)));
        check("c_post_rst1", pop_cap(2), 32'(ent(2, 1'b1, 8'h0A)));
        check("c_errs", cnt_pe[2] + cnt_fe[2] + cnt_dr[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
